// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and the default number of valid memory words.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  localparam int MEM_DEPTH_DEF = 65536;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-request round-robin picker. On a tie the port that was not granted
// last wins; a single request always wins alone.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  // Pure combinational pick: tie goes to the port opposite the last grant.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      grant = ~last;
    end else begin
      grant = req1;
    end
  end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter. Each transaction walks
// IDLE -> ACCESS -> DONE: the winner's request is latched in IDLE, the memory
// is strobed for exactly one ACCESS cycle (memory responds on negedge), and
// DONE pulses the winner's ack. All outputs are registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // One extra bit so the depth constant always fits next to the address.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= DEPTH_L);
  endfunction

  state_e              state_q, state_d;
  logic                sel_q, sel_d;     // winning port of the current transaction
  logic                we_q, we_d;
  logic                oor_q, oor_d;     // latched address is out of range
  logic                last_q, last_d;   // port granted most recently
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;

  logic                gnt;
  logic                gnt_vld;
  logic [ADDR_W-1:0]   win_addr;
  logic                win_we;

  rr_arb2 u_rr (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .grant (gnt),
    .valid (gnt_vld)
  );

  assign win_addr = gnt ? addr1 : addr0;
  assign win_we   = gnt ? we1 : we0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    we_d        = we_q;
    oor_d       = oor_q;
    last_d      = last_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          sel_d       = gnt;
          we_d        = win_we;
          oor_d       = out_of_range(win_addr);
          mem_addr_d  = win_addr;
          mem_wdata_d = gnt ? wdata1 : wdata0;
          // Out-of-range accesses never reach the memory.
          mem_read_d  = !win_we && !out_of_range(win_addr);
          mem_write_d = win_we && !out_of_range(win_addr);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!sel_q) begin
          ack0_d = 1'b1;
          err0_d = oor_q;
          if (oor_q) begin
            rdata0_d = '0;
          end else if (!we_q) begin
            rdata0_d = mem_rdata;
          end
        end else begin
          ack1_d = 1'b1;
          err1_d = oor_q;
          if (oor_q) begin
            rdata1_d = '0;
          end else if (!we_q) begin
            rdata1_d = mem_rdata;
          end
        end
      end
      DONE: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output and latch registers; reset also kills in-flight strobes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      last_q      <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      last_q      <= last_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: negedge memory model, scoreboard of expected acks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_rd[2];
  logic [31:0] mem[0:255];
  int          total = 0;
  int          bad = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(65536)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Data memory acting on negedge; preload while rst is high.
  always @(negedge clk) begin
    if (rst) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h01] <= 32'hA1A1A1A1;
      mem[8'h02] <= 32'hB2B2B2B2;
    end else begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Output monitor: strobe exclusivity, strobe counts, scoreboard on ack.
  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read || mem_write) check_eq("strobe_excl", 64'(mem_read & mem_write), 64'd0);
    if (ack0 || ack1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_ack", 64'({ack1, ack0}), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("ack_port", 64'({ack1, ack0}), e.port ? 64'd2 : 64'd1);
        check_eq("err", 64'(e.port ? err1 : err0), 64'(e.err));
        check_eq("rdata", 64'(e.port ? rdata1 : rdata0), 64'(e.rdata));
      end
    end
  end

  task automatic push_exp(input bit port, input bit err, input bit is_rd, input logic [31:0] rd);
    exp_t e;
    if (is_rd) exp_rd[port] = rd;
    e.port  = port;
    e.err   = err;
    e.rdata = exp_rd[port];
    sb.push_back(e);
  endtask

  task automatic do_req(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    if (!port) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    else       begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if ((!port && ack0) || (port && ack1)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("ack_timeout", 64'd0, 64'd1);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    int lat, n, rd0, wr0;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", 64'({ack1, ack0, err1, err0}), 64'd0);
    check_eq("rst_strobe", 64'({mem_read, mem_write, busy}), 64'd0);
    check_eq("rst_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_wdata", 64'(mem_wdata), 64'd0);
    check_eq("rst_rdata", 64'(rdata0 | rdata1), 64'd0);
    rst = 1'b0;

    // Single read on port 0.
    rd0 = rd_cnt; wr0 = wr_cnt;
    push_exp(0, 0, 1, 32'hDEADBEEF);
    do_req(0, 0, 32'h10, 32'h0, lat);
    check_eq("read_latency", 64'(lat), 64'd2);
    @(posedge clk); #1;
    check_eq("read_rd_cnt", 64'(rd_cnt - rd0), 64'd1);
    check_eq("read_wr_cnt", 64'(wr_cnt - wr0), 64'd0);
    check_eq("rdata0_hold", 64'(rdata0), 64'hDEADBEEF);

    // Port 1 write then read back.
    rd0 = rd_cnt; wr0 = wr_cnt;
    push_exp(1, 0, 0, 32'h0);
    do_req(1, 1, 32'h20, 32'h12345678, lat);
    @(posedge clk); #1;
    check_eq("write_wr_cnt", 64'(wr_cnt - wr0), 64'd1);
    check_eq("write_rd_cnt", 64'(rd_cnt - rd0), 64'd0);
    push_exp(1, 0, 1, 32'h12345678);
    do_req(1, 0, 32'h20, 32'h0, lat);
    @(posedge clk); #1;
    check_eq("wr_rd_rd_cnt", 64'(rd_cnt - rd0), 64'd1);

    // Tie: both held for four transactions, expect 0,1,0,1.
    rd0 = rd_cnt;
    push_exp(0, 0, 1, 32'hA1A1A1A1);
    push_exp(1, 0, 1, 32'hB2B2B2B2);
    push_exp(0, 0, 1, 32'hA1A1A1A1);
    push_exp(1, 0, 1, 32'hB2B2B2B2);
    req0 = 1; we0 = 0; addr0 = 32'h1;
    req1 = 1; we1 = 0; addr1 = 32'h2;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) n++;
      if (n == 4) break;
    end
    req0 = 0; req1 = 0;
    check_eq("tie_acks", 64'(n), 64'd4);
    repeat (2) @(posedge clk); #1;
    check_eq("tie_rd_cnt", 64'(rd_cnt - rd0), 64'd4);

    // Out-of-range read on port 0.
    rd0 = rd_cnt; wr0 = wr_cnt;
    push_exp(0, 1, 1, 32'h0);
    do_req(0, 0, 32'h0001_0000, 32'h0, lat);
    @(posedge clk); #1;
    check_eq("oor_strobes", 64'((rd_cnt - rd0) + (wr_cnt - wr0)), 64'd0);

    // Reset asserted mid-ACCESS.
    req0 = 1; we0 = 0; addr0 = 32'h10;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mem_read) begin n = 1; break; end
    end
    check_eq("rst_access_reached", 64'(n), 64'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("rst_drop_strobe", 64'({mem_read, mem_write}), 64'd0);
    check_eq("rst_drop_busy", 64'(busy), 64'd0);
    req0 = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("rst_no_ack", 64'({ack1, ack0}), 64'd0);
    end
    rst = 1'b0;
    push_exp(1, 0, 1, 32'h12345678);
    do_req(1, 0, 32'h20, 32'h0, lat);
    check_eq("post_rst_latency", 64'(lat), 64'd2);
    repeat (3) @(posedge clk); #1;
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, requester and memory data width.
REQ-002 Parameter ADDR_W, default 32, requester and memory address width.
REQ-003 Parameter MEM_DEPTH, default 65536, number of valid memory words.
REQ-004 Port clk  input  1  single clock; all registers update on posedge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Ports req0/req1  input  1  requester n access request, held until ackn.
REQ-007 Ports we0/we1  input  1  requester n write (1) or read (0); stable while reqn.
REQ-008 Ports addr0/addr1  input  ADDR_W  requester n word address; stable while reqn.
REQ-009 Ports wdata0/wdata1  input  DATA_W  requester n write data; stable while reqn.
REQ-010 Ports ack0/ack1  output  1  one-cycle completion pulse to requester n.
REQ-011 Ports rdata0/rdata1  output  DATA_W  read data, valid in the ackn cycle, held until the next ackn.
REQ-012 Ports err0/err1  output  1  out-of-range flag, valid only with ackn.
REQ-013 Port mem_read  output  1  read strobe to the data memory.
REQ-014 Port mem_write  output  1  write strobe to the data memory.
REQ-015 Port mem_addr  output  ADDR_W  memory address.
REQ-016 Port mem_wdata  output  DATA_W  memory write data.
REQ-017 Port mem_rdata  input  DATA_W  memory read data; memory acts on negedge clk.
REQ-018 Port busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, ACCESS, DONE; all memory-side and requester-side outputs registered.
REQ-020 IDLE: with any reqn high, select a winner via round-robin, latch its we/addr/wdata, go to ACCESS; with none high, stay in IDLE.
REQ-021 Round-robin: one request wins alone; with both high, the port not granted last wins; the last-grant pointer resets to 1, so port 0 wins the first tie.
REQ-022 ACCESS lasts exactly one cycle: mem_read=!we or mem_write=we asserted for that cycle, with mem_addr/mem_wdata from the latch.
REQ-023 Never assert mem_read and mem_write together; both stay 0 outside ACCESS.
REQ-024 On leaving ACCESS, capture mem_rdata into the winner's rdata for reads; leave rdata unchanged for writes.
REQ-025 DONE: pulse ack of the winner only, update last-grant pointer, return to IDLE; new requests are not sampled in DONE.
REQ-026 Latency: req sampled at posedge N gives ACCESS in cycle N+1, ackn in cycle N+2, next grant no earlier than N+3.
REQ-027 Each requester drops reqn or presents a new request in the cycle after ackn; a reqn still high then counts as a new request.
REQ-028 Out-of-range address (addr >= MEM_DEPTH): ACCESS keeps mem_read/mem_write low, DONE asserts errn with ackn, rdata set to 0.
REQ-029 A loser keeps its request pending with no ack and wins the next arbitration, so starvation-free service is guaranteed.
REQ-030 A reqn dropped before its grant is treated as withdrawn, with no ack and no memory access.

Reset
REQ-031 While rst is high: state IDLE; ack0/ack1/err0/err1/mem_read/mem_write/busy=0; mem_addr/mem_wdata/rdata0/rdata1=0; pointer=1.
REQ-032 rst asserted mid-ACCESS drops the memory strobes asynchronously and issues no ack; the in-flight transaction is lost.
REQ-033 First arbitration happens at the first posedge after rst deasserts.

Structure
REQ-034 Shared package mem_arb_pkg holds the state encoding (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10) and the MEM_DEPTH default constant.
REQ-035 One sub-module rr_arb2: combinational two-request round-robin picker (inputs req0, req1, last; output grant index and valid).

Verification
REQ-036 Single read: port0 reads addr 0x10 preloaded with 0xDEADBEEF -> mem_read for 1 cycle, ack0 two cycles after req, rdata0=0xDEADBEEF, err0=0.
REQ-037 Write then read: port1 writes 0x12345678 to 0x20, then reads 0x20 -> one mem_write cycle, then rdata1=0x12345678.
REQ-038 Tie, both held high for 4 transactions -> grants alternate 0,1,0,1; never two strobes in one cycle.
REQ-039 Out of range: port0 reads 0x00010000 -> no memory strobe, ack0 with err0=1, rdata0=0.
REQ-040 Reset in ACCESS: assert rst mid-cycle -> strobes drop immediately, no ack; after release, a port1 request is served normally.
